div_share_ctrl: RTL and testbench
=================================

// Module: div_share_ctrl
// PURPOSE
//  Sequencer/arbiter that shares the single multi-cycle divider between the two EX issue slots.
//  Accepts per-slot divide requests and serves them in program order (slot1 before slot2).
//  Drives the divider start/annul handshake, holds the pipeline via stallreq_o until all pending
//  divides finish, then presents both 64-bit {hi,lo} results. Sits between ex_top and the divider.
// PARAMETERS
//  TIMEOUT_CYC  64  max cycles in BUSY before the watchdog aborts the op (must exceed divider latency)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   reset; synchronous, active-high
//  flush_i         in   1   pipeline flush; aborts all pending work
//  stall_i         in   1   pipeline stalled elsewhere; EX instructions stay put
//  req1_valid_i    in   1   slot1 divide request (held by EX until result consumed)
//  req1_signed_i   in   1   slot1 signed divide
//  req1_op1_i      in   32  slot1 dividend
//  req1_op2_i      in   32  slot1 divisor
//  req2_valid_i    in   1   slot2 divide request
//  req2_signed_i   in   1   slot2 signed divide
//  req2_op1_i      in   32  slot2 dividend
//  req2_op2_i      in   32  slot2 divisor
//  div_ready_i     in   1   divider done pulse (1 cycle)
//  div_result_i    in   64  divider result {remainder,quotient}
//  div_start_o     out  1   divider start; level, held until div_ready_i
//  div_annul_o     out  1   divider abort pulse (1 cycle)
//  div_signed_o    out  1   signedness of operation in flight
//  div_op1_o       out  32  dividend to divider
//  div_op2_o       out  32  divisor to divider
//  result1_o       out  64  slot1 result {hi,lo}
//  result2_o       out  64  slot2 result {hi,lo}
//  result_valid_o  out  1   results valid (state DONE)
//  err_o           out  1   sticky watchdog error; cleared by rst only
//  stallreq_o      out  1   stall request to the pipeline controller
// BEHAVIOUR
//  Reset: every registered output is 0; state IDLE; pending mask cleared. Flush has the same effect except err_o.
//  States: IDLE, BUSY, GAP, DONE.
//  - IDLE: on any reqN_valid_i, latch operands/signedness of both valid slots and set pending mask;
//    next state BUSY, serving slot1 if pending, else slot2.
//  - BUSY: div_start_o=1 with the served slot's operands. On div_ready_i, capture div_result_i into that
//    slot's result register and clear its pending bit. If the other slot is still pending -> GAP, else -> DONE.
//  - GAP: div_start_o=0 for exactly 1 cycle (mandatory divider rearm), then BUSY for the next slot.
//  - DONE: result_valid_o=1, stallreq_o=0, requests ignored. Leave to IDLE in the first cycle with stall_i=0.
//  Divide by zero: a served slot with op2==0 never starts the divider; its result is 64'h0 and it
//    costs 1 cycle (BUSY without start), then follows the normal GAP/DONE exit.
//  stallreq_o (combinational) = (IDLE & (req1_valid_i|req2_valid_i)) | BUSY | GAP; 0 in DONE.
//  Latency: one request, divider ready N cycles after start rises -> result_valid_o in cycle N+2
//    after the request is first seen. Two requests: 2N+4.
//  Flush in BUSY: div_annul_o pulses 1 cycle, div_start_o drops the same cycle, state IDLE, results cleared.
//    Flush in the same cycle as div_ready_i: flush wins, result discarded. Flush in IDLE/GAP/DONE: no annul.
//  Watchdog: cycle counter cleared on entry to BUSY; at TIMEOUT_CYC cycles -> annul pulse, slot result 64'h0,
//    err_o set, continue as if div_ready_i had arrived.
//  Reset mid-operation: no annul pulse (the divider is reset too); all state cleared next edge.
//  Unsigned/signed interpretation is the divider's job; this block only forwards the signed flag.
// STRUCTURE
//  State encodings (DivIdle/DivBusy/DivGap/DivDone) and TIMEOUT default go in defines.v.
//  One sub-module: div_wdog_cnt (clear/enable/expire counter sized $clog2(TIMEOUT_CYC+1)).
//  Arbitration is a fixed-order pending-mask pick inside this block; no separate arbiter module.
// TESTING
//  1 slot1 100/7 unsigned, model ready after 8 cycles -> result1_o=64'h00000002_0000000E, stallreq_o low in DONE.
//  2 both slots: 100/7 and -9/2 signed -> start low exactly 1 cycle between ops; result2_o=64'hFFFFFFFF_FFFFFFFC.
//  3 slot2 only, op2=0 -> div_start_o never rises, result2_o=0, result_valid_o 2 cycles after request.
//  4 flush 3 cycles into BUSY -> div_annul_o 1-cycle pulse, state IDLE, result_valid_o stays 0.
//  5 divider never responds, TIMEOUT_CYC=64 -> annul at cycle 64 of BUSY, err_o=1, result 0, DONE.
//  6 DONE with stall_i=1 for 5 cycles, requests held -> no relaunch, outputs stable, IDLE after stall_i falls.

Source files
------------

// File: rtl/div_share_ctrl_pkg.sv
// Shared types and defaults for the EX-stage divider sharing controller.
// Imported by the sequencer top and its watchdog counter.
package div_share_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_GAP  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef struct packed {
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
  } div_req_t;

endpackage

// File: rtl/div_wdog_cnt.sv
// Watchdog cycle counter: cleared while clr_i is high, counts enabled cycles,
// flags expiry during the LIMIT-th enabled cycle.
module div_wdog_cnt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one multi-cycle divider between the two EX issue slots, serving slot1
// before slot2, stalling the pipeline until both results are available.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        req1_valid_i,
  input  logic        req1_signed_i,
  input  logic [31:0] req1_op1_i,
  input  logic [31:0] req1_op2_i,
  input  logic        req2_valid_i,
  input  logic        req2_signed_i,
  input  logic [31:0] req2_op1_i,
  input  logic [31:0] req2_op2_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic [63:0] result1_o,
  output logic [63:0] result2_o,
  output logic        result_valid_o,
  output logic        err_o,
  output logic        stallreq_o
);

  div_state_e  state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic        sel_q, sel_d;
  div_req_t    req1_q, req1_d, req2_q, req2_d;
  div_req_t    cur, nxt;
  logic [63:0] res1_q, res1_d, res2_q, res2_d;
  logic [63:0] slot_res;
  logic        start_q, start_d;
  logic        annul_q, annul_d;
  logic        sgn_q, sgn_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        div_zero;
  logic        wd_expire;

  div_wdog_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != DIV_BUSY),
    .en_i     ((state_q == DIV_BUSY) && start_q),
    .expire_o (wd_expire)
  );

  assign cur      = sel_q ? req2_q : req1_q;
  assign div_zero = (cur.op2 == '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    pend_d   = pend_q;
    sel_d    = sel_q;
    req1_d   = req1_q;
    req2_d   = req2_q;
    res1_d   = res1_q;
    res2_d   = res2_q;
    err_d    = err_q;
    annul_d  = 1'b0;
    slot_res = '0;

    unique case (state_q)
      DIV_IDLE: begin
        if (req1_valid_i || req2_valid_i) begin
          if (req1_valid_i) req1_d = {req1_signed_i, req1_op1_i, req1_op2_i};
          if (req2_valid_i) req2_d = {req2_signed_i, req2_op1_i, req2_op2_i};
          pend_d  = {req2_valid_i, req1_valid_i};
          sel_d   = ~req1_valid_i;
          res1_d  = '0;
          res2_d  = '0;
          state_d = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (div_zero || div_ready_i || wd_expire) begin
          // A real divider answer wins over a coincident watchdog expiry.
          if (!div_zero && div_ready_i) begin
            slot_res = div_result_i;
          end else if (!div_zero) begin
            annul_d = 1'b1;
            err_d   = 1'b1;
          end
          if (sel_q) res2_d = slot_res;
          else       res1_d = slot_res;
          pend_d[sel_q] = 1'b0;
          if (pend_q[~sel_q]) begin
            sel_d   = ~sel_q;
            state_d = DIV_GAP;
          end else begin
            state_d = DIV_DONE;
          end
        end
      end
      DIV_GAP:  state_d = DIV_BUSY;
      DIV_DONE: if (!stall_i) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    if (flush_i) begin
      state_d = DIV_IDLE;
      pend_d  = '0;
      res1_d  = '0;
      res2_d  = '0;
      err_d   = err_q;
      annul_d = (state_q == DIV_BUSY);
    end

    nxt = sel_d ? req2_d : req1_d;
    if (state_d == DIV_BUSY) begin
      sgn_d   = nxt.sgn;
      op1_d   = nxt.op1;
      op2_d   = nxt.op2;
      start_d = (nxt.op2 != '0);
    end else begin
      sgn_d   = 1'b0;
      op1_d   = '0;
      op2_d   = '0;
      start_d = 1'b0;
    end
    valid_d = (state_d == DIV_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      pend_q  <= '0;
      sel_q   <= 1'b0;
      req1_q  <= '0;
      req2_q  <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      start_q <= 1'b0;
      annul_q <= 1'b0;
      sgn_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      req1_q  <= req1_d;
      req2_q  <= req2_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      start_q <= start_d;
      annul_q <= annul_d;
      sgn_q   <= sgn_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign div_start_o    = start_q;
  assign div_annul_o    = annul_q;
  assign div_signed_o   = sgn_q;
  assign div_op1_o      = op1_q;
  assign div_op2_o      = op2_q;
  assign result1_o      = res1_q;
  assign result2_o      = res2_q;
  assign result_valid_o = valid_q;
  assign err_o          = err_q;
  assign stallreq_o     = ((state_q == DIV_IDLE) && (req1_valid_i || req2_valid_i))
                        || (state_q == DIV_BUSY) || (state_q == DIV_GAP);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider that answers
// a fixed number of cycles after start rises.
module tb_div_share_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush_i, stall_i;
  logic        req1_valid_i, req1_signed_i, req2_valid_i, req2_signed_i;
  logic [31:0] req1_op1_i, req1_op2_i, req2_op1_i, req2_op2_i;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic [63:0] result1_o, result2_o;
  logic        result_valid_o, err_o, stallreq_o;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 8;
  bit model_on = 1'b1;
  int scnt    = 0;

  div_share_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .stall_i        (stall_i),
    .req1_valid_i   (req1_valid_i),
    .req1_signed_i  (req1_signed_i),
    .req1_op1_i     (req1_op1_i),
    .req1_op2_i     (req1_op2_i),
    .req2_valid_i   (req2_valid_i),
    .req2_signed_i  (req2_signed_i),
    .req2_op1_i     (req2_op1_i),
    .req2_op2_i     (req2_op2_i),
    .div_ready_i    (div_ready_i),
    .div_result_i   (div_result_i),
    .div_start_o    (div_start_o),
    .div_annul_o    (div_annul_o),
    .div_signed_o   (div_signed_o),
    .div_op1_o      (div_op1_o),
    .div_op2_o      (div_op2_o),
    .result1_o      (result1_o),
    .result2_o      (result2_o),
    .result_valid_o (result_valid_o),
    .err_o          (err_o),
    .stallreq_o     (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    logic [31:0] uq, ur;
    if (sgn) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Advance one cycle and sample #1 later; the divider model reacts to div_start_o.
  task automatic tick();
    @(posedge clk);
    #1;
    if (div_start_o && model_on) begin
      scnt++;
      if (scnt == lat + 1) begin
        div_ready_i  = 1'b1;
        div_result_i = model_div(div_signed_o, div_op1_o, div_op2_o);
      end else begin
        div_ready_i = 1'b0;
      end
    end else begin
      scnt        = 0;
      div_ready_i = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!result_valid_o && n < 200);
  endtask

  task automatic clear_reqs();
    req1_valid_i = 1'b0;
    req2_valid_i = 1'b0;
  endtask

  int n, gap, rises;
  bit prev_start;
  logic [63:0] hold_res;

  initial begin
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    req1_valid_i = 1'b0; req1_signed_i = 1'b0; req1_op1_i = '0; req1_op2_i = '0;
    req2_valid_i = 1'b0; req2_signed_i = 1'b0; req2_op1_i = '0; req2_op2_i = '0;
    div_ready_i = 1'b0; div_result_i = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_start",    div_start_o,    0);
    check("rst_valid",    result_valid_o, 0);
    check("rst_err",      err_o,          0);
    check("rst_stallreq", stallreq_o,     0);
    check("rst_res1",     result1_o,      0);

    // 1: slot1 100/7 unsigned
    req1_valid_i = 1'b1; req1_signed_i = 1'b0; req1_op1_i = 32'd100; req1_op2_i = 32'd7;
    #1;
    check("t1_stallreq_idle", stallreq_o, 1);
    wait_valid(n);
    check("t1_latency",  n,          10);
    check("t1_result1",  result1_o,  64'h00000002_0000000E);
    check("t1_stallreq", stallreq_o, 0);
    clear_reqs();
    tick();
    check("t1_valid_drop", result_valid_o, 0);

    // 2: both slots, 100/7 unsigned then -9/2 signed
    req1_valid_i = 1'b1; req1_signed_i = 1'b0; req1_op1_i = 32'd100;        req1_op2_i = 32'd7;
    req2_valid_i = 1'b1; req2_signed_i = 1'b1; req2_op1_i = 32'hFFFFFFF7;  req2_op2_i = 32'd2;
    n = 0; gap = 0; rises = 0; prev_start = 1'b0;
    do begin
      tick();
      n++;
      if (div_start_o && !prev_start) rises++;
      if (!div_start_o && rises > 0 && !result_valid_o) gap++;
      prev_start = div_start_o;
    end while (!result_valid_o && n < 200);
    check("t2_latency", n,         20);
    check("t2_gap",     gap,       1);
    check("t2_rises",   rises,     2);
    check("t2_result1", result1_o, 64'h00000002_0000000E);
    check("t2_result2", result2_o, 64'hFFFFFFFF_FFFFFFFC);
    clear_reqs();
    tick();

    // 3: slot2 only, divide by zero
    req2_valid_i = 1'b1; req2_signed_i = 1'b0; req2_op1_i = 32'd55; req2_op2_i = 32'd0;
    n = 0; rises = 0;
    do begin
      tick();
      n++;
      if (div_start_o) rises++;
    end while (!result_valid_o && n < 200);
    check("t3_latency",  n,         2);
    check("t3_no_start", rises,     0);
    check("t3_result2",  result2_o, 0);
    check("t3_err",      err_o,     0);
    clear_reqs();
    tick();

    // 4: flush three cycles into BUSY
    req1_valid_i = 1'b1; req1_signed_i = 1'b0; req1_op1_i = 32'd100; req1_op2_i = 32'd7;
    tick(); tick(); tick();
    check("t4_busy_start", div_start_o, 1);
    flush_i = 1'b1;
    clear_reqs();
    tick();
    flush_i = 1'b0;
    check("t4_annul",    div_annul_o, 1);
    check("t4_start",    div_start_o, 0);
    check("t4_stallreq", stallreq_o,  0);
    tick();
    check("t4_annul_pulse", div_annul_o, 0);
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (result_valid_o || div_start_o) rises++;
    end
    check("t4_quiet", rises,     0);
    check("t4_res1",  result1_o, 0);

    // 5: divider never answers, watchdog fires
    model_on = 1'b0;
    req1_valid_i = 1'b1; req1_signed_i = 1'b0; req1_op1_i = 32'd100; req1_op2_i = 32'd7;
    n = 0;
    tick();
    while (div_start_o && n < 200) begin
      n++;
      tick();
    end
    check("t5_busy_cycles", n,              64);
    check("t5_annul",       div_annul_o,    1);
    check("t5_err",         err_o,          1);
    check("t5_valid",       result_valid_o, 1);
    check("t5_result1",     result1_o,      0);
    clear_reqs();
    tick();
    check("t5_annul_pulse", div_annul_o, 0);
    model_on = 1'b1;
    tick();

    // 6: DONE held by stall_i with requests still asserted
    req1_valid_i = 1'b1; req1_signed_i = 1'b0; req1_op1_i = 32'd100; req1_op2_i = 32'd7;
    wait_valid(n);
    check("t6_latency", n, 10);
    hold_res = result1_o;
    stall_i = 1'b1;
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!result_valid_o || div_start_o || stallreq_o || result1_o !== hold_res) rises++;
    end
    check("t6_stable",  rises,     0);
    check("t6_result1", result1_o, 64'h00000002_0000000E);
    stall_i = 1'b0;
    tick();
    check("t6_idle_valid", result_valid_o, 0);
    check("t6_idle_start", div_start_o,    0);
    clear_reqs();
    tick();
    check("t6_err_sticky", err_o, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_rst_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
